// File: rtl/ddr_port_arbiter_pkg.sv
// rtl/ddr_port_arbiter_pkg.sv - shared types and defaults for the DDR port arbiter
//
// Purpose: DDR address/data types, requester count and watchdog defaults,
//          requester index type and the arbiter state encoding.
// Ports:   none (package).
package ddr_port_arbiter_pkg;

  localparam int DdrAddrWidth     = 32;
  localparam int DdrDataWidth     = 32;
  localparam int NumDdrRequesters = 2;
  localparam int DdrTimeoutCycles = 1024;

  typedef logic [DdrAddrWidth-1:0] ddr_address_t;
  typedef logic [DdrDataWidth-1:0] ddr_data_t;

  typedef logic [$clog2(NumDdrRequesters)-1:0] ddr_req_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2
  } ddr_arb_state_t;

endpackage

// File: rtl/ddr_port_arbiter_rr_arbiter.sv
// rtl/ddr_port_arbiter_rr_arbiter.sv - combinational round-robin pick for the DDR port
//
// Purpose: picks the first eligible requester strictly after the pointer,
//          wrapping around; eligible = req & lock_mask.
// Ports:
//   req         in   N       active requests
//   pointer     in   idx     last winner; search starts at pointer+1
//   lock_mask   in   N       requesters allowed to win this round
//   grant       out  N       one-hot winner (zero if none)
//   grant_idx   out  idx     winner index
//   grant_valid out  1       a winner exists
module ddr_port_arbiter_rr_arbiter #(
  parameter int NumRequesters = 2,
  localparam int IdxWidth     = $clog2(NumRequesters)
) (
  input  logic [NumRequesters-1:0] req,
  input  logic [IdxWidth-1:0]      pointer,
  input  logic [NumRequesters-1:0] lock_mask,
  output logic [NumRequesters-1:0] grant,
  output logic [IdxWidth-1:0]      grant_idx,
  output logic                     grant_valid
);

  logic [NumRequesters-1:0] eligible;
  logic [IdxWidth-1:0]      idx_hi;
  logic [IdxWidth-1:0]      idx_lo;
  logic                     found_hi;
  logic                     found_lo;

  assign eligible = req & lock_mask;

  // Lowest eligible index above the pointer wins; otherwise wrap to the
  // lowest eligible index overall. Scanning downwards lets the last hit
  // be the lowest one.
  always_comb begin
    idx_hi   = '0;
    idx_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        found_lo = 1'b1;
        idx_lo   = IdxWidth'(k);
        if (k > int'(pointer)) begin
          found_hi = 1'b1;
          idx_hi   = IdxWidth'(k);
        end
      end
    end
    grant_valid = found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
    grant       = '0;
    if (found_lo) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - round-robin owner arbiter for the single DDR port
//
// Purpose: grants one read or write at a time to one of N masters, with an
//          optional lock, owner-only response routing and a watchdog.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_address_i/req_w_data_i    per-requester address / write data
//   req_r_en_i/req_w_en_i         per-requester level requests
//   req_lock_i                    owner keeps the grant across accesses
//   req_r_data_o                  DDR read data broadcast
//   req_r_valid_o/req_w_done_o    owner-only completion strobes
//   grant_o                       registered one-hot owner
//   ddr_address_o/ddr_w_data_o    registered DDR address / write data
//   ddr_r_en_o/ddr_w_en_o         registered DDR enables
//   ddr_r_data_i/ddr_r_valid_i/ddr_w_done_i  DDR responses
//   timeout_o/protocol_err_o      sticky error flags
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NumRequesters = NumDdrRequesters,
  parameter int TimeoutCycles = DdrTimeoutCycles
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  ddr_address_t             req_address_i [NumRequesters],
  input  logic [NumRequesters-1:0] req_r_en_i,
  input  logic [NumRequesters-1:0] req_w_en_i,
  input  ddr_data_t                req_w_data_i  [NumRequesters],
  input  logic [NumRequesters-1:0] req_lock_i,
  output ddr_data_t                req_r_data_o,
  output logic [NumRequesters-1:0] req_r_valid_o,
  output logic [NumRequesters-1:0] req_w_done_o,
  output logic [NumRequesters-1:0] grant_o,
  output ddr_address_t             ddr_address_o,
  output logic                     ddr_w_en_o,
  output ddr_data_t                ddr_w_data_o,
  output logic                     ddr_r_en_o,
  input  ddr_data_t                ddr_r_data_i,
  input  logic                     ddr_r_valid_i,
  input  logic                     ddr_w_done_i,
  output logic                     timeout_o,
  output logic                     protocol_err_o
);

  localparam int IdxWidth = $clog2(NumRequesters);
  localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  ddr_arb_state_t           state_q, state_d;
  logic [IdxWidth-1:0]      ptr_q;        // last winner == current owner
  logic                     owner_valid_q; // ptr_q names a real owner that may hold a lock
  logic [NumRequesters-1:0] grant_q;
  ddr_address_t             addr_q;
  ddr_data_t                wdata_q;
  logic                     r_en_q, w_en_q;
  logic [CntWidth-1:0]      cnt_q;
  logic                     timeout_q, perr_q;

  logic [NumRequesters-1:0] active;
  logic [NumRequesters-1:0] lock_mask;
  logic [NumRequesters-1:0] arb_grant;
  logic [IdxWidth-1:0]      arb_idx;
  logic                     arb_valid;
  logic                     resp_hit;
  logic                     wd_expire;

  assign active = req_r_en_i | req_w_en_i;

  // A locked owner excludes everyone else, even while it has nothing to ask.
  always_comb begin
    lock_mask = '1;
    if (owner_valid_q && req_lock_i[ptr_q]) begin
      lock_mask        = '0;
      lock_mask[ptr_q] = 1'b1;
    end
  end

  ddr_port_arbiter_rr_arbiter #(
    .NumRequesters(NumRequesters)
  ) u_rr (
    .req        (active),
    .pointer    (ptr_q),
    .lock_mask  (lock_mask),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign resp_hit  = ((state_q == BUSY_RD) && ddr_r_valid_i) ||
                     ((state_q == BUSY_WR) && ddr_w_done_i);
  // A response in the last allowed cycle still counts as a completion.
  assign wd_expire = (TimeoutCycles != 0) && (state_q != IDLE) && !resp_hit &&
                     (cnt_q == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_r_valid_o = '0;
    req_w_done_o  = '0;
    case (state_q)
      IDLE: begin
        // Write wins when a requester raises both enables.
        if (arb_valid) begin
          state_d = req_w_en_i[arb_idx] ? BUSY_WR : BUSY_RD;
        end
      end
      BUSY_RD: begin
        if (ddr_r_valid_i) begin
          req_r_valid_o = grant_q;
        end
        if (resp_hit || wd_expire) begin
          state_d = IDLE;
        end
      end
      BUSY_WR: begin
        if (ddr_w_done_i) begin
          req_w_done_o = grant_q;
        end
        if (resp_hit || wd_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q         <= IdxWidth'(NumRequesters - 1);
      owner_valid_q <= 1'b0;
      grant_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      r_en_q        <= 1'b0;
      w_en_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      r_en_q <= (state_d == BUSY_RD);
      w_en_q <= (state_d == BUSY_WR);
      if (|(req_r_en_i & req_w_en_i)) begin
        perr_q <= 1'b1;
      end
      if (state_q == IDLE) begin
        grant_q <= arb_grant;
        if (arb_valid) begin
          ptr_q         <= arb_idx;
          owner_valid_q <= 1'b1;
          addr_q        <= req_address_i[arb_idx];
          wdata_q       <= req_w_data_i[arb_idx];
          cnt_q         <= '0;
        end
      end else if (wd_expire) begin
        timeout_q     <= 1'b1;
        owner_valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign req_r_data_o   = ddr_r_data_i;
  assign grant_o        = grant_q;
  assign ddr_address_o  = addr_q;
  assign ddr_w_data_o   = wdata_q;
  assign ddr_r_en_o     = r_en_q;
  assign ddr_w_en_o     = w_en_q;
  assign timeout_o      = timeout_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
  import ddr_port_arbiter_pkg::*;

  localparam int N = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  ddr_address_t req_address_i [N];
  logic [N-1:0] req_r_en_i, req_w_en_i, req_lock_i;
  ddr_data_t    req_w_data_i [N];
  ddr_data_t    req_r_data_o;
  logic [N-1:0] req_r_valid_o, req_w_done_o, grant_o;
  ddr_address_t ddr_address_o;
  logic         ddr_w_en_o, ddr_r_en_o;
  ddr_data_t    ddr_w_data_o, ddr_r_data_i;
  logic         ddr_r_valid_i, ddr_w_done_i;
  logic         timeout_o, protocol_err_o;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.NumRequesters(N), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_address_i(req_address_i), .req_r_en_i(req_r_en_i), .req_w_en_i(req_w_en_i),
    .req_w_data_i(req_w_data_i), .req_lock_i(req_lock_i),
    .req_r_data_o(req_r_data_o), .req_r_valid_o(req_r_valid_o), .req_w_done_o(req_w_done_o),
    .grant_o(grant_o), .ddr_address_o(ddr_address_o), .ddr_w_en_o(ddr_w_en_o),
    .ddr_w_data_o(ddr_w_data_o), .ddr_r_en_o(ddr_r_en_o), .ddr_r_data_i(ddr_r_data_i),
    .ddr_r_valid_i(ddr_r_valid_i), .ddr_w_done_i(ddr_w_done_i),
    .timeout_o(timeout_o), .protocol_err_o(protocol_err_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) begin
      req_address_i[k] = '0;
      req_w_data_i[k]  = '0;
    end
    req_r_en_i = '0; req_w_en_i = '0; req_lock_i = '0;
    ddr_r_data_i = '0; ddr_r_valid_i = 1'b0; ddr_w_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  typedef struct {
    int          k;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;       // busy-cycle index of the DDR response (>= T: none)
    int          exp_busy;
    bit          exp_timeout;
    bit          exp_perr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int           busy;
    logic [N-1:0] oh;
    oh = N'(1) << v.k;
    req_r_en_i[v.k] = v.rd; req_w_en_i[v.k] = v.wr;
    req_address_i[v.k] = v.addr; req_w_data_i[v.k] = v.data;
    @(posedge clk); #1;
    check("vec_en_type", {ddr_w_en_o, ddr_r_en_o}, v.wr ? 2'b10 : 2'b01);
    check("vec_grant", grant_o, oh);
    check("vec_addr", ddr_address_o, v.addr);
    busy = 0;
    for (int i = 0; i < 20 && (ddr_r_en_o || ddr_w_en_o); i++) begin
      busy++;
      if (v.wr) check("vec_wdata_stable", ddr_w_data_o, v.data);
      if (i == v.delay) begin
        ddr_r_valid_i = !v.wr; ddr_w_done_i = v.wr; ddr_r_data_i = v.data ^ 32'h0000_FFFF;
        #1;
        check("vec_r_valid", req_r_valid_o, v.wr ? '0 : oh);
        check("vec_w_done", req_w_done_o, v.wr ? oh : '0);
        if (!v.wr) check("vec_r_data", req_r_data_o, v.data ^ 32'h0000_FFFF);
      end
      @(posedge clk); #1;
      ddr_r_valid_i = 1'b0; ddr_w_done_i = 1'b0;
    end
    req_r_en_i[v.k] = 1'b0; req_w_en_i[v.k] = 1'b0;
    check("vec_busy_cycles", busy, v.exp_busy);
    check("vec_gap", {ddr_w_en_o, ddr_r_en_o}, 2'b00);
    check("vec_timeout", timeout_o, v.exp_timeout);
    check("vec_perr", protocol_err_o, v.exp_perr);
    @(posedge clk); #1;
    check("vec_idle", {ddr_w_en_o, ddr_r_en_o, grant_o}, '0);
  endtask

  // Reference-model state for the random phase.
  int           m_ptr, m_owner, m_idx, m_delay, win;
  bit           m_hold, m_busy, m_wr, m_to, m_perr, locked, hit;
  logic [31:0]  m_addr, m_data;
  logic [N-1:0] m_grant;
  bit           done_k [N];

  initial begin
    int exp_owner [5];
    int starts;
    bit prev;

    rst_i = 1'b1;
    idle_inputs();
    #2;
    check("rst_enables", {ddr_w_en_o, ddr_r_en_o}, 2'b00);
    check("rst_grant", grant_o, '0);
    check("rst_addr_data", {ddr_address_o, ddr_w_data_o}, '0);
    check("rst_flags", {timeout_o, protocol_err_o}, 2'b00);
    do_reset();

    vecs[0] = '{0, 1, 0, 32'h40,  32'h0,         3,  4, 0, 0};
    vecs[1] = '{1, 0, 1, 32'h100, 32'hDEADBEEF,  2,  3, 0, 0};
    vecs[2] = '{0, 0, 1, 32'h200, 32'h12345678,  0,  1, 0, 0};
    vecs[3] = '{1, 1, 0, 32'h300, 32'h0BADF00D,  7,  8, 0, 0};
    vecs[4] = '{0, 1, 0, 32'h400, 32'h0,         20, 8, 1, 0};
    vecs[5] = '{1, 1, 1, 32'h500, 32'hCAFEF00D,  1,  2, 1, 1};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a write.
    req_w_en_i[0] = 1'b1; req_address_i[0] = 32'h600; req_w_data_i[0] = 32'h55AA55AA;
    @(posedge clk); #1;
    check("rst_mid_wr_active", ddr_w_en_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_wr_en", {ddr_w_en_o, ddr_r_en_o}, 2'b00);
    check("rst_mid_wr_grant", grant_o, '0);
    check("rst_mid_wr_flags", {timeout_o, protocol_err_o}, 2'b00);
    req_w_en_i[0] = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Two continuous readers alternate, starting with requester 0.
    req_r_en_i = 2'b11;
    starts = 0; prev = 1'b0;
    for (int c = 0; c < 30 && starts < 4; c++) begin
      @(posedge clk); #1;
      if (ddr_r_en_o && !prev) begin
        check("rr_alternate", grant_o, N'(1) << (starts % 2));
        starts++;
      end
      prev = ddr_r_en_o;
      ddr_r_valid_i = ddr_r_en_o;
    end
    check("rr_starts", starts, 4);
    @(posedge clk); #1;
    do_reset();

    // Locked requester 0 keeps four accesses, then requester 1 gets one.
    exp_owner = '{0, 0, 0, 0, 1};
    req_lock_i[0] = 1'b1;
    req_r_en_i = 2'b11;
    starts = 0; prev = 1'b0;
    for (int c = 0; c < 40 && starts < 5; c++) begin
      @(posedge clk); #1;
      if (ddr_r_en_o && !prev) begin
        check("lock_owner", grant_o, N'(1) << exp_owner[starts]);
        starts++;
      end
      if (!ddr_r_en_o && starts == 4) req_lock_i[0] = 1'b0;
      prev = ddr_r_en_o;
      ddr_r_valid_i = ddr_r_en_o;
    end
    check("lock_starts", starts, 5);
    @(posedge clk); #1;
    do_reset();

    // Randomized traffic against a transaction-level model.
    m_ptr = N - 1; m_hold = 0; m_busy = 0; m_to = 0; m_perr = 0; m_grant = '0;
    m_owner = 0; m_idx = 0; m_delay = 0; m_wr = 0; m_addr = '0; m_data = '0;
    for (int k = 0; k < N; k++) done_k[k] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (|(req_r_en_i & req_w_en_i)) m_perr = 1;
      if (!m_busy) begin
        win = -1;
        locked = m_hold && req_lock_i[m_ptr];
        for (int s = 1; s <= N; s++) begin
          int c;
          c = (m_ptr + s) % N;
          if (win < 0 && (req_r_en_i[c] || req_w_en_i[c]) && (!locked || c == m_ptr)) win = c;
        end
        if (win >= 0) begin
          m_busy = 1; m_owner = win; m_wr = req_w_en_i[win];
          m_addr = req_address_i[win]; m_data = req_w_data_i[win];
          m_ptr = win; m_hold = 1; m_idx = 0; m_delay = $urandom_range(0, 9);
          m_grant = N'(1) << win;
        end else begin
          m_grant = '0;
        end
      end else begin
        if (m_wr ? ddr_w_done_i : ddr_r_valid_i) m_busy = 0;
        else if (m_idx == T - 1) begin m_busy = 0; m_to = 1; m_hold = 0; end
        else m_idx++;
      end
      check("rnd_r_en", ddr_r_en_o, m_busy && !m_wr);
      check("rnd_w_en", ddr_w_en_o, m_busy && m_wr);
      check("rnd_grant", grant_o, m_grant);
      if (m_busy) check("rnd_addr", ddr_address_o, m_addr);
      if (m_busy && m_wr) check("rnd_wdata", ddr_w_data_o, m_data);
      check("rnd_flags", {timeout_o, protocol_err_o}, {m_to, m_perr});

      for (int k = 0; k < N; k++) begin
        if (done_k[k]) begin
          req_r_en_i[k] = 1'b0; req_w_en_i[k] = 1'b0; done_k[k] = 0;
        end
        if (!(req_r_en_i[k] || req_w_en_i[k])) begin
          if ($urandom_range(0, 2) == 0) begin
            int rw;
            rw = $urandom_range(0, 15);
            req_w_en_i[k] = (rw < 8);
            req_r_en_i[k] = (rw >= 8) || (rw == 0);
            req_address_i[k] = $urandom;
            req_w_data_i[k]  = $urandom;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_r_en_i[k] = 1'b0; req_w_en_i[k] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) req_lock_i[k] = ~req_lock_i[k];
      end

      ddr_r_data_i = $urandom;
      if (m_busy) begin
        hit = (m_idx == m_delay);
        ddr_r_valid_i = m_wr ? ($urandom_range(0, 7) == 0) : hit;
        ddr_w_done_i  = m_wr ? hit : ($urandom_range(0, 7) == 0);
      end else begin
        ddr_r_valid_i = ($urandom_range(0, 7) == 0);
        ddr_w_done_i  = ($urandom_range(0, 7) == 0);
      end
      #1;
      check("rnd_r_valid", req_r_valid_o,
            (m_busy && !m_wr && ddr_r_valid_i) ? N'(1) << m_owner : '0);
      check("rnd_w_done", req_w_done_o,
            (m_busy && m_wr && ddr_w_done_i) ? N'(1) << m_owner : '0);
      check("rnd_r_data", req_r_data_o, ddr_r_data_i);
      if (m_busy && (m_wr ? ddr_w_done_i : ddr_r_valid_i)) done_k[m_owner] = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
